// File: rtl/rr_lock_arb.sv
// rr_lock_arb: round-robin arbiter with grant locking.
// A grant is held until the owner pulses done or drops its request; one idle
// cycle always separates consecutive grants. Define ARB_HOLD_TIMEOUT_EN to
// force release of a grant after MAX_HOLD cycles (pulsing preempt).
module rr_lock_arb #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDW      = $clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt, ptr_adv;
  logic [IDW-1:0] win_idx, id_nxt;
  logic           win_found;
  logic [N-1:0]   gnt_nxt;
  logic           busy_nxt;
  logic           owner_rel;
  logic           force_rel;
  int unsigned    scan_pos;

  // Owner gives up the grant by completing or by withdrawing its request.
  assign owner_rel = done | ~req[gnt_id];
  // Next rotate start: one past the owner, wrapping N-1 -> 0.
  assign ptr_adv   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD - 1);

  logic [15:0] hold_cnt, hold_nxt;
  logic        limit_hit;

  assign limit_hit = (hold_cnt == HOLD_LIM);
  // A normal release in the limit cycle takes precedence and is not a preempt.
  assign force_rel = (state == GRANT) && !owner_rel && limit_hit;

  // Hold counter: zero in IDLE so it starts at 0 on grant entry, saturating.
  always_comb begin
    hold_nxt = hold_cnt;
    if (state == IDLE)
      hold_nxt = '0;
    else if (!limit_hit)
      hold_nxt = hold_cnt + 16'd1;
  end

  // Hold counter and one-cycle preempt pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_nxt;
      preempt  <= force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  // MAX_HOLD has no effect in this build; the compare folds to 0.
  assign preempt   = (MAX_HOLD < 1);
`endif

  // Round-robin scan: first set request starting at ptr, wrapping past N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_pos = 32'(ptr) + i;
      if (scan_pos >= N)
        scan_pos = scan_pos - N;
      if (!win_found && req[scan_pos[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_pos[IDW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    busy_nxt  = busy;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt        = GRANT;
          gnt_nxt          = '0;
          gnt_nxt[win_idx] = 1'b1;
          id_nxt           = win_idx;
          busy_nxt         = 1'b1;
        end
      end
      GRANT: begin
        if (owner_rel || force_rel) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          ptr_nxt   = ptr_adv;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      gnt    <= gnt_nxt;
      gnt_id <= id_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rr_lock_arb.sv
// Testbench for rr_lock_arb (N=4, MAX_HOLD=4): vector table, hand-written
// corner sequences and randomized traffic against an integer reference model.
module tb_rr_lock_arb;

  localparam int N  = 4;
  localparam int MH = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         preempt;

  int total = 0;
  int bad   = 0;

  rr_lock_arb #(.N(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rstn(rstn), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  // reference model state
  int m_owner, m_ptr, m_id, m_hold;
  bit m_pre;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = '0;
    done = 1'b0;
    rstn = 1'b0;
    #3;
    chk("rst gnt", 32'(gnt), 0);
    chk("rst gnt_id", 32'(gnt_id), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst preempt", 32'(preempt), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_id = 0; m_hold = 0; m_pre = 1'b0;
  endfunction

  // One clock edge of the arbiter rules, given inputs seen before the edge.
  function automatic void model_step(input logic [3:0] r, input logic d);
    bit rel, forced;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && r[idx]) begin
          m_owner = idx; m_id = idx; m_hold = 0;
        end
      end
    end else begin
      rel    = d || !r[m_owner];
      forced = TMO && !rel && (m_hold >= MH - 1);
      if (rel || forced) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_pre   = forced;
      end else if (m_hold < MH - 1) begin
        m_hold++;
      end
    end
  endfunction

  task automatic model_check(input string tag);
    chk({tag, " gnt"}, 32'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
    chk({tag, " gnt_id"}, 32'(gnt_id), 32'(m_id));
    chk({tag, " busy"}, 32'(busy), (m_owner < 0) ? 0 : 1);
    chk({tag, " preempt"}, 32'(preempt), 32'(m_pre));
    chk({tag, " onehot"}, 32'($countones(gnt) <= 1), 1);
  endtask

  initial begin
    logic [3:0] rq;
    rstn = 1'b0; req = '0; done = 1'b0;

    // 0110 held, done two cycles after each grant
    vt.push_back('{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd1, 1'b0});
    vt.push_back('{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd2, 1'b0});
    vt.push_back('{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 1'b1, 4'b0000, 2'd1, 1'b0});
    // 1111 held, done after every grant: full rotation
    vt.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
    vt.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
    vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0});
    vt.push_back('{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
    vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0});
    vt.push_back('{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
    vt.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0});
    vt.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
    // owner 2 ignores others, then drops req; req[3] wins next
    vt.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vt.push_back('{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1});
    vt.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd2, 1'b0});
    vt.push_back('{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1});
    // done and req drop together: single release; done while idle ignored
    vt.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
    vt.push_back('{1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0});
    vt.push_back('{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1});
    vt.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0});
    vt.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      req  = vt[i].req;
      done = vt[i].done;
      step();
      chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(vt[i].gnt));
      chk($sformatf("vec%0d gnt_id", i), 32'(gnt_id), 32'(vt[i].id));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].busy));
      chk($sformatf("vec%0d preempt", i), 32'(preempt), 0);
    end

    // async reset mid-grant, then rotation restarts at requester 0
    do_reset();
    req = 4'b0100;
    step();
    chk("midrst pre gnt", 32'(gnt), 32'h4);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst gnt", 32'(gnt), 0);
    chk("midrst busy", 32'(busy), 0);
    req = 4'b1111;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();
    chk("postrst gnt", 32'(gnt), 32'h1);
    chk("postrst gnt_id", 32'(gnt_id), 0);

`ifdef ARB_HOLD_TIMEOUT_EN
    // req[1] held without done: 4 grant cycles, preempt pulse, regrant
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < MH; c++) begin
      step();
      chk($sformatf("tmo hold%0d gnt", c), 32'(gnt), 32'h2);
      chk($sformatf("tmo hold%0d preempt", c), 32'(preempt), 0);
    end
    step();
    chk("tmo rel gnt", 32'(gnt), 0);
    chk("tmo rel preempt", 32'(preempt), 1);
    step();
    chk("tmo regrant gnt", 32'(gnt), 32'h2);
    chk("tmo regrant preempt", 32'(preempt), 0);
`endif

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      rq   = rq ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      req  = rq;
      done = ($urandom_range(0, 3) == 0);
      step();
      model_step(rq, done);
      model_check($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
